// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the ALU arbiter: two operand/request channels plus the shared result/done return.
interface alu_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             Req0;
    logic [WIDTH-1:0] OpA0;
    logic [WIDTH-1:0] OpB0;
    logic             Req1;
    logic [WIDTH-1:0] OpA1;
    logic [WIDTH-1:0] OpB1;
    logic             Done0;
    logic             Done1;
    logic [WIDTH-1:0] Result;
    logic             Busy;

    modport slave (
        input  Req0, OpA0, OpB0, Req1, OpA1, OpB1,
        output Done0, Done1, Result, Busy
    );

    modport master (
        output Req0, OpA0, OpB0, Req1, OpA1, OpB1,
        input  Done0, Done1, Result, Busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one adder ALU between two requesters: IDLE -> ISSUE -> DONE.
module alu_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_arbiter_if.slave     bus,
    output logic             ALUOp,
    output logic [WIDTH-1:0] ALUInA,
    output logic [WIDTH-1:0] ALUInB,
    input  logic [WIDTH-1:0] ALUOutput,
    output logic [7:0]       OpCount
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] ina_q, ina_d;
    logic [WIDTH-1:0] inb_q, inb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             win;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            ina_q    <= '0;
            inb_q    <= '0;
            result_q <= '0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            ina_q    <= ina_d;
            inb_q    <= inb_d;
            result_q <= result_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        ina_d    = ina_q;
        inb_d    = inb_q;
        result_d = result_q;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        cnt_d    = cnt_q;
        win      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.Req0 || bus.Req1) begin
                    // On a tie the requester that did not win last time goes next
                    win     = (bus.Req0 && bus.Req1) ? ~last_q : bus.Req1;
                    grant_d = win;
                    last_d  = win;
                    ina_d   = win ? bus.OpA1 : bus.OpA0;
                    inb_d   = win ? bus.OpB1 : bus.OpB0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                result_d = ALUOutput;
                done0_d  = ~grant_q;
                done1_d  = grant_q;
                state_d  = DONE;
            end
            DONE: begin
                cnt_d   = cnt_q + 8'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ALUOp      = (state_q == ISSUE);
    assign ALUInA     = ina_q;
    assign ALUInB     = inb_q;
    assign OpCount    = cnt_q;
    assign bus.Done0  = done0_q;
    assign bus.Done1  = done1_q;
    assign bus.Result = result_q;
    assign bus.Busy   = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; models the shared adder ALU externally.
module tb_alu_arbiter;
    logic       clk;
    logic       rst_n;
    logic       ALUOp;
    logic [7:0] ALUInA;
    logic [7:0] ALUInB;
    logic [7:0] ALUOutput;
    logic [7:0] OpCount;

    int unsigned checks;
    int unsigned failures;

    alu_arbiter_if #(.WIDTH(8)) bus ();

    alu_arbiter #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .ALUOp     (ALUOp),
        .ALUInA    (ALUInA),
        .ALUInB    (ALUInB),
        .ALUOutput (ALUOutput),
        .OpCount   (OpCount)
    );

    // Shared ALU: only produces a sum while enabled
    assign ALUOutput = ALUOp ? ALUInA + ALUInB : 8'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for a Done pulse on either channel, bounded to a few cycles
    task automatic wait_done(output logic d0, output logic d1, output logic [7:0] res);
        logic seen;
        seen = 1'b0;
        d0 = 1'b0;
        d1 = 1'b0;
        res = '0;
        for (int n = 0; n < 8 && !seen; n++) begin
            tick();
            if (bus.Done0 || bus.Done1) begin
                seen = 1'b1;
                d0 = bus.Done0;
                d1 = bus.Done1;
                res = bus.Result;
            end
        end
        check("done_timeout", {31'd0, seen}, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic d0, d1;
        logic [7:0] res;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.Req0 = 1'b0; bus.OpA0 = 8'd0; bus.OpB0 = 8'd0;
        bus.Req1 = 1'b0; bus.OpA1 = 8'd0; bus.OpB1 = 8'd0;
        tick();
        tick();

        check("rst_done0", {31'd0, bus.Done0}, 32'd0);
        check("rst_done1", {31'd0, bus.Done1}, 32'd0);
        check("rst_result", {24'd0, bus.Result}, 32'd0);
        check("rst_busy", {31'd0, bus.Busy}, 32'd0);
        check("rst_aluop", {31'd0, ALUOp}, 32'd0);
        check("rst_alu_a", {24'd0, ALUInA}, 32'd0);
        check("rst_alu_b", {24'd0, ALUInB}, 32'd0);
        check("rst_opcount", {24'd0, OpCount}, 32'd0);

        // Test 1: single request 3+4
        rst_n = 1'b1;
        bus.Req0 = 1'b1; bus.OpA0 = 8'd3; bus.OpB0 = 8'd4;
        tick();
        check("t1_aluop", {31'd0, ALUOp}, 32'd1);
        check("t1_busy", {31'd0, bus.Busy}, 32'd1);
        check("t1_alu_a", {24'd0, ALUInA}, 32'd3);
        check("t1_alu_b", {24'd0, ALUInB}, 32'd4);
        check("t1_early_done", {31'd0, bus.Done0}, 32'd0);
        tick();
        check("t1_done0", {31'd0, bus.Done0}, 32'd1);
        check("t1_done1", {31'd0, bus.Done1}, 32'd0);
        check("t1_result", {24'd0, bus.Result}, 32'd7);
        check("t1_aluop_off", {31'd0, ALUOp}, 32'd0);
        bus.Req0 = 1'b0;
        tick();
        check("t1_done0_end", {31'd0, bus.Done0}, 32'd0);
        check("t1_opcount", {24'd0, OpCount}, 32'd1);
        check("t1_idle", {31'd0, bus.Busy}, 32'd0);
        tick();
        check("t1_no_regrant", {31'd0, bus.Busy}, 32'd0);

        // Test 2: both requesters held continuously from reset
        do_reset();
        bus.Req0 = 1'b1; bus.OpA0 = 8'd10; bus.OpB0 = 8'd20;
        bus.Req1 = 1'b1; bus.OpA1 = 8'd5;  bus.OpB1 = 8'd6;
        for (int k = 1; k <= 12; k++) begin
            logic exp_d0, exp_d1;
            tick();
            exp_d0 = (k % 3 == 2) && ((k / 3) % 2 == 0);
            exp_d1 = (k % 3 == 2) && ((k / 3) % 2 == 1);
            check($sformatf("t2_done0_c%0d", k), {31'd0, bus.Done0}, {31'd0, exp_d0});
            check($sformatf("t2_done1_c%0d", k), {31'd0, bus.Done1}, {31'd0, exp_d1});
            check($sformatf("t2_busy_c%0d", k), {31'd0, bus.Busy}, {31'd0, (k % 3 != 0)});
            if (exp_d0) check($sformatf("t2_res0_c%0d", k), {24'd0, bus.Result}, 32'd30);
            if (exp_d1) check($sformatf("t2_res1_c%0d", k), {24'd0, bus.Result}, 32'd11);
        end
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
        check("t2_opcount", {24'd0, OpCount}, 32'd4);

        // Test 3: wrap-around sum, operand change after grant ignored
        bus.Req1 = 1'b1; bus.OpA1 = 8'd200; bus.OpB1 = 8'd100;
        tick();
        check("t3_aluop", {31'd0, ALUOp}, 32'd1);
        bus.OpA1 = 8'd1;
        tick();
        check("t3_done1", {31'd0, bus.Done1}, 32'd1);
        check("t3_done0", {31'd0, bus.Done0}, 32'd0);
        check("t3_result", {24'd0, bus.Result}, 32'd44);
        bus.Req1 = 1'b0;
        tick();
        tick();
        check("t3_result_hold", {24'd0, bus.Result}, 32'd44);
        check("t3_opcount", {24'd0, OpCount}, 32'd5);

        // Test 4: reset during ISSUE
        bus.Req0 = 1'b1; bus.OpA0 = 8'd9; bus.OpB0 = 8'd9;
        tick();
        check("t4_issue", {31'd0, ALUOp}, 32'd1);
        rst_n = 1'b0;
        bus.Req0 = 1'b0;
        tick();
        check("t4_busy", {31'd0, bus.Busy}, 32'd0);
        check("t4_done0", {31'd0, bus.Done0}, 32'd0);
        check("t4_result", {24'd0, bus.Result}, 32'd0);
        check("t4_opcount", {24'd0, OpCount}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("t4_done0_after", {31'd0, bus.Done0}, 32'd0);
        bus.Req0 = 1'b1; bus.OpA0 = 8'd1;  bus.OpB0 = 8'd2;
        bus.Req1 = 1'b1; bus.OpA1 = 8'd50; bus.OpB1 = 8'd50;
        tick();
        check("t4_tie_alu_a", {24'd0, ALUInA}, 32'd1);
        tick();
        check("t4_tie_done0", {31'd0, bus.Done0}, 32'd1);
        check("t4_tie_result", {24'd0, bus.Result}, 32'd3);
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
        tick();
        check("t4_opcount_after", {24'd0, OpCount}, 32'd1);

        // Test 5: 256 operations wrap OpCount, then back-to-back request
        do_reset();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] a;
            a = i[7:0];
            bus.Req0 = 1'b1; bus.OpA0 = a; bus.OpB0 = 8'd1;
            wait_done(d0, d1, res);
            check($sformatf("t5_done0_%0d", i), {31'd0, d0}, 32'd1);
            check($sformatf("t5_res_%0d", i), {24'd0, res}, {24'd0, a + 8'd1});
            bus.Req0 = 1'b0;
            tick();
            if (i == 254) check("t5_opcount_255", {24'd0, OpCount}, 32'd255);
        end
        check("t5_opcount_wrap", {24'd0, OpCount}, 32'd0);
        bus.Req0 = 1'b1; bus.OpA0 = 8'd7; bus.OpB0 = 8'd8;
        wait_done(d0, d1, res);
        check("t5_b2b_first", {24'd0, res}, 32'd15);
        tick();
        check("t5_b2b_idle", {31'd0, bus.Busy}, 32'd0);
        bus.OpA0 = 8'd20; bus.OpB0 = 8'd22;
        tick();
        check("t5_b2b_issue", {31'd0, ALUOp}, 32'd1);
        tick();
        check("t5_b2b_done0", {31'd0, bus.Done0}, 32'd1);
        check("t5_b2b_result", {24'd0, bus.Result}, 32'd42);
        bus.Req0 = 1'b0;
        tick();
        check("t5_b2b_opcount", {24'd0, OpCount}, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
